// File: rtl/rs_station.sv
`default_nettype none
// ============================================================================
// Module   : rs_station
// Purpose  : Reservation station for a Tomasulo back end. Holds dispatched
//            instructions until both operands are ready, wakes operands from
//            the CDB channels, and issues one instruction per cycle to an ALU
//            through a registered valid/ready stage. Flushes on misprediction.
// Config   : RS_AGE_EN - when defined, an age matrix makes selection pick the
//            oldest ready entry; otherwise the lowest-index ready entry wins.
// Revision : 1.0 - initial release
// ============================================================================
module rs_station #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 6,
  parameter int N_CDB = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic                   disp_valid,
  input  logic [OP_W-1:0]        disp_op,
  input  logic [XLEN-1:0]        disp_imm,
  input  logic [XLEN-1:0]        disp_pc,
  input  logic [TAG_W-1:0]       disp_rob,
  input  logic                   disp_q1_rdy,
  input  logic [XLEN-1:0]        disp_v1,
  input  logic [TAG_W-1:0]       disp_q1,
  input  logic                   disp_q2_rdy,
  input  logic [XLEN-1:0]        disp_v2,
  input  logic [TAG_W-1:0]       disp_q2,
  input  logic [N_CDB-1:0]       cdb_valid,
  input  logic [N_CDB*TAG_W-1:0] cdb_tag,
  input  logic [N_CDB*XLEN-1:0]  cdb_val,
  output logic                   full,
  output logic [CNT_W-1:0]       count,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [OP_W-1:0]        iss_op,
  output logic [XLEN-1:0]        iss_imm,
  output logic [XLEN-1:0]        iss_pc,
  output logic [TAG_W-1:0]       iss_rob,
  output logic [XLEN-1:0]        iss_v1,
  output logic [XLEN-1:0]        iss_v2
);

  localparam int IDX_W = $clog2(DEPTH);

  // Entry storage
  logic             r_valid [DEPTH];
  logic [OP_W-1:0]  r_op    [DEPTH];
  logic [XLEN-1:0]  r_imm   [DEPTH];
  logic [XLEN-1:0]  r_pc    [DEPTH];
  logic [TAG_W-1:0] r_rob   [DEPTH];
  logic             r_q1rdy [DEPTH];
  logic [XLEN-1:0]  r_v1    [DEPTH];
  logic [TAG_W-1:0] r_q1    [DEPTH];
  logic             r_q2rdy [DEPTH];
  logic [XLEN-1:0]  r_v2    [DEPTH];
  logic [TAG_W-1:0] r_q2    [DEPTH];

  logic [CNT_W-1:0] r_count;

  // Issue stage
  logic             r_iss_valid;
  logic [OP_W-1:0]  r_iss_op;
  logic [XLEN-1:0]  r_iss_imm;
  logic [XLEN-1:0]  r_iss_pc;
  logic [TAG_W-1:0] r_iss_rob;
  logic [XLEN-1:0]  r_iss_v1;
  logic [XLEN-1:0]  r_iss_v2;

`ifdef RS_AGE_EN
  // r_age[i][j] = 1 means entry i was dispatched before entry j
  logic [DEPTH-1:0] r_age [DEPTH];
`endif

  // CDB lookups: {hit, value}, lowest channel wins
  logic [XLEN:0]    w_lk1 [DEPTH];
  logic [XLEN:0]    w_lk2 [DEPTH];
  logic [XLEN:0]    w_byp1;
  logic [XLEN:0]    w_byp2;

  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_cand;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_sel_found;
  logic             w_full;
  logic             w_stage_free;
  logic             w_disp_take;
  logic             w_issue;

  function automatic logic [XLEN:0] cdb_lookup(
    input logic [TAG_W-1:0]       tag,
    input logic [N_CDB-1:0]       vld,
    input logic [N_CDB*TAG_W-1:0] tags,
    input logic [N_CDB*XLEN-1:0]  vals
  );
    logic [XLEN:0] res;
    res = '0;
    for (int ch = N_CDB - 1; ch >= 0; ch--) begin
      if (vld[ch] && (tags[ch*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, vals[ch*XLEN +: XLEN]};
      end
    end
    return res;
  endfunction

  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_stage_free = !r_iss_valid || iss_ready;
  assign w_disp_take  = disp_valid && !w_full;
  assign w_issue      = w_stage_free && w_sel_found;
  assign w_byp1       = cdb_lookup(disp_q1, cdb_valid, cdb_tag, cdb_val);
  assign w_byp2       = cdb_lookup(disp_q2, cdb_valid, cdb_tag, cdb_val);

  // Per-entry wake-up lookups against this cycle's broadcasts
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_lk1[i] = cdb_lookup(r_q1[i], cdb_valid, cdb_tag, cdb_val);
      w_lk2[i] = cdb_lookup(r_q2[i], cdb_valid, cdb_tag, cdb_val);
    end
  end

  // Lowest-index free slot for dispatch (freed entries become usable next cycle)
  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  // Ready mask and candidate filtering (oldest-only when age tracking is on)
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_ready[i] = r_valid[i] && r_q1rdy[i] && r_q2rdy[i];
    end
    w_cand = w_ready;
`ifdef RS_AGE_EN
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((i != j) && w_ready[j] && !r_age[i][j]) w_cand[i] = 1'b0;
      end
    end
`endif
  end

  // Pick the lowest-index candidate
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
  end

  // Entry array, occupancy count and issue stage update
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
      r_count     <= '0;
      r_iss_valid <= 1'b0;
      r_iss_op    <= '0;
      r_iss_imm   <= '0;
      r_iss_pc    <= '0;
      r_iss_rob   <= '0;
      r_iss_v1    <= '0;
      r_iss_v2    <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
        r_count     <= '0;
        r_iss_valid <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_valid[i] && !r_q1rdy[i] && w_lk1[i][XLEN]) begin
            r_q1rdy[i] <= 1'b1;
            r_v1[i]    <= w_lk1[i][XLEN-1:0];
          end
          if (r_valid[i] && !r_q2rdy[i] && w_lk2[i][XLEN]) begin
            r_q2rdy[i] <= 1'b1;
            r_v2[i]    <= w_lk2[i][XLEN-1:0];
          end
        end
        if (w_stage_free) begin
          if (w_sel_found) begin
            r_iss_valid          <= 1'b1;
            r_iss_op             <= r_op[w_sel_idx];
            r_iss_imm            <= r_imm[w_sel_idx];
            r_iss_pc             <= r_pc[w_sel_idx];
            r_iss_rob            <= r_rob[w_sel_idx];
            r_iss_v1             <= r_v1[w_sel_idx];
            r_iss_v2             <= r_v2[w_sel_idx];
            r_valid[w_sel_idx]   <= 1'b0;
          end else begin
            r_iss_valid <= 1'b0;
          end
        end
        if (w_disp_take) begin
          r_valid[w_free_idx] <= 1'b1;
          r_op[w_free_idx]    <= disp_op;
          r_imm[w_free_idx]   <= disp_imm;
          r_pc[w_free_idx]    <= disp_pc;
          r_rob[w_free_idx]   <= disp_rob;
          r_q1[w_free_idx]    <= disp_q1;
          r_q2[w_free_idx]    <= disp_q2;
          r_q1rdy[w_free_idx] <= disp_q1_rdy || w_byp1[XLEN];
          r_q2rdy[w_free_idx] <= disp_q2_rdy || w_byp2[XLEN];
          r_v1[w_free_idx]    <= disp_q1_rdy ? disp_v1 : w_byp1[XLEN-1:0];
          r_v2[w_free_idx]    <= disp_q2_rdy ? disp_v2 : w_byp2[XLEN-1:0];
        end
        r_count <= r_count + CNT_W'(w_disp_take) - CNT_W'(w_issue);
      end
    end
  end

`ifdef RS_AGE_EN
  // Newly dispatched entry becomes younger than every other entry
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
    end else if (rdy_in && !flush_in && w_disp_take) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i != int'(w_free_idx)) r_age[i][w_free_idx] <= 1'b1;
        r_age[w_free_idx][i] <= 1'b0;
      end
    end
  end
`endif

  assign full      = w_full;
  assign count     = r_count;
  assign iss_valid = r_iss_valid;
  assign iss_op    = r_iss_op;
  assign iss_imm   = r_iss_imm;
  assign iss_pc    = r_iss_pc;
  assign iss_rob   = r_iss_rob;
  assign iss_v1    = r_iss_v1;
  assign iss_v2    = r_iss_v2;

endmodule
`default_nettype wire

// File: tb/tb_rs_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_station
// Purpose  : Self-checking bench for rs_station: directed scenarios followed
//            by randomized traffic, all checked against an entry-list model
//            that orders entries by dispatch sequence number.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_station;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int OP_W  = 6;
  localparam int N_CDB = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   clk_in = 1'b0;
  logic                   rst_n_in, rdy_in, flush_in, disp_valid;
  logic [OP_W-1:0]        disp_op;
  logic [XLEN-1:0]        disp_imm, disp_pc, disp_v1, disp_v2;
  logic [TAG_W-1:0]       disp_rob, disp_q1, disp_q2;
  logic                   disp_q1_rdy, disp_q2_rdy;
  logic [N_CDB-1:0]       cdb_valid;
  logic [N_CDB*TAG_W-1:0] cdb_tag;
  logic [N_CDB*XLEN-1:0]  cdb_val;
  logic                   full, iss_valid, iss_ready;
  logic [CNT_W-1:0]       count;
  logic [OP_W-1:0]        iss_op;
  logic [XLEN-1:0]        iss_imm, iss_pc, iss_v1, iss_v2;
  logic [TAG_W-1:0]       iss_rob;

  rs_station #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .N_CDB(N_CDB)) u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_rob(disp_rob), .disp_q1_rdy(disp_q1_rdy), .disp_v1(disp_v1), .disp_q1(disp_q1),
    .disp_q2_rdy(disp_q2_rdy), .disp_v2(disp_v2), .disp_q2(disp_q2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .full(full), .count(count), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_rob(iss_rob),
    .iss_v1(iss_v1), .iss_v2(iss_v2)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  typedef struct {
    bit               v, r1, r2;
    logic [XLEN-1:0]  v1, v2, imm, pc;
    logic [TAG_W-1:0] q1, q2, rob;
    logic [OP_W-1:0]  op;
    int unsigned      seq;
  } ent_t;

  ent_t        m_e [DEPTH];
  ent_t        m_iss;
  bit          m_iv;
  int unsigned m_seq = 0;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cdb_find(input logic [TAG_W-1:0] tag, output logic [XLEN-1:0] val);
    for (int c = 0; c < N_CDB; c++) begin
      if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == tag) begin
        val = cdb_val[c*XLEN +: XLEN];
        return 1'b1;
      end
    end
    val = '0;
    return 1'b0;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_e[i].v) n++;
    return n;
  endfunction

  // Apply the station's rules for one clock edge using the current inputs
  task automatic model_edge();
    int nvalid, fidx, best;
    logic [XLEN-1:0] val;
    ent_t ne;
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) m_e[i].v = 1'b0;
      m_iv = 1'b0;
      m_iss.op = '0; m_iss.imm = '0; m_iss.pc = '0;
      m_iss.rob = '0; m_iss.v1 = '0; m_iss.v2 = '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < DEPTH; i++) m_e[i].v = 1'b0;
        m_iv = 1'b0;
      end else begin
        nvalid = m_count();
        fidx = -1;
        best = -1;
        for (int i = 0; i < DEPTH; i++) if (!m_e[i].v && fidx < 0) fidx = i;
        for (int i = 0; i < DEPTH; i++) begin
          if (m_e[i].v && m_e[i].r1 && m_e[i].r2) begin
`ifdef RS_AGE_EN
            if (best < 0 || m_e[i].seq < m_e[best].seq) best = i;
`else
            if (best < 0) best = i;
`endif
          end
        end
        if (!m_iv || iss_ready) begin
          if (best >= 0) begin
            m_iss = m_e[best];
            m_iv = 1'b1;
            m_e[best].v = 1'b0;
          end else begin
            m_iv = 1'b0;
          end
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (m_e[i].v && !m_e[i].r1 && cdb_find(m_e[i].q1, val)) begin m_e[i].r1 = 1'b1; m_e[i].v1 = val; end
          if (m_e[i].v && !m_e[i].r2 && cdb_find(m_e[i].q2, val)) begin m_e[i].r2 = 1'b1; m_e[i].v2 = val; end
        end
        if (disp_valid && nvalid < DEPTH) begin
          ne.v = 1'b1; ne.op = disp_op; ne.imm = disp_imm; ne.pc = disp_pc; ne.rob = disp_rob;
          ne.q1 = disp_q1; ne.q2 = disp_q2;
          ne.r1 = disp_q1_rdy; ne.v1 = disp_v1;
          ne.r2 = disp_q2_rdy; ne.v2 = disp_v2;
          if (!disp_q1_rdy && cdb_find(disp_q1, val)) begin ne.r1 = 1'b1; ne.v1 = val; end
          if (!disp_q2_rdy && cdb_find(disp_q2, val)) begin ne.r2 = 1'b1; ne.v2 = val; end
          ne.seq = m_seq++;
          m_e[fidx] = ne;
        end
      end
    end
  endtask

  // One clock: update the model, let the DUT clock, then compare off-edge
  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    check("count", 64'(count), 64'(m_count()));
    check("full", 64'(full), 64'(m_count() == DEPTH));
    check("iss_valid", 64'(iss_valid), 64'(m_iv));
    if (m_iv) begin
      check("iss_rob", 64'(iss_rob), 64'(m_iss.rob));
      check("iss_op", 64'(iss_op), 64'(m_iss.op));
      check("iss_imm", 64'(iss_imm), 64'(m_iss.imm));
      check("iss_pc", 64'(iss_pc), 64'(m_iss.pc));
      check("iss_v1", 64'(iss_v1), 64'(m_iss.v1));
      check("iss_v2", 64'(iss_v2), 64'(m_iss.v2));
    end
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0; disp_valid = 1'b0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    iss_ready = 1'b1;
  endtask

  task automatic set_disp(input logic [TAG_W-1:0] rob, input bit r1, input logic [XLEN-1:0] v1,
                          input logic [TAG_W-1:0] q1, input bit r2, input logic [XLEN-1:0] v2,
                          input logic [TAG_W-1:0] q2);
    disp_valid = 1'b1; disp_rob = rob;
    disp_op = OP_W'(rob) + 6'd1; disp_imm = 32'h1000 + 32'(rob); disp_pc = 32'h4000 + 32'(rob) * 4;
    disp_q1_rdy = r1; disp_v1 = v1; disp_q1 = q1;
    disp_q2_rdy = r2; disp_v2 = v2; disp_q2 = q2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TAG_W-1:0] first_rob;
    rst_n_in = 1'b0;
    idle();
    set_disp(4'd0, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    disp_valid = 1'b0;

    // 1: reset
    step(); step();
    check("reset_iss_v1", 64'(iss_v1), 64'd0);
    rst_n_in = 1'b1;

    // 2: fill with pending tag 3, overflow attempt, then broadcast on ch1
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(4'(i), 1'b0, 32'd0, 4'd3, 1'b0, 32'd0, 4'd3);
      step();
    end
    check("fill_count", 64'(count), 64'd16);
    check("fill_full", 64'(full), 64'd1);
    set_disp(4'd15, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    step();
    check("overflow_count", 64'(count), 64'd16);
    idle();
    cdb_valid = 2'b10; cdb_tag = {4'd3, 4'd0}; cdb_val = {32'hABCD, 32'h0};
    step();
    idle();
    for (int i = 0; i < DEPTH + 2; i++) step();
    check("drain_count", 64'(count), 64'd0);

    // 3: same-cycle bypass
    set_disp(4'd1, 1'b0, 32'd0, 4'd5, 1'b1, 32'h22, 4'd0);
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_val = {32'h0, 32'h11};
    step();
    idle();
    step();
    check("bypass_valid", 64'(iss_valid), 64'd1);
    check("bypass_v1", 64'(iss_v1), 64'h11);
    check("bypass_v2", 64'(iss_v2), 64'h22);
    step();

    // 4: backpressure
    iss_ready = 1'b0;
    set_disp(4'd7, 1'b1, 32'h70, 4'd0, 1'b1, 32'h71, 4'd0);
    step();
    set_disp(4'd8, 1'b1, 32'h80, 4'd0, 1'b1, 32'h81, 4'd0);
    step();
    disp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_rob", 64'(iss_rob), 64'd7);
    end
    iss_ready = 1'b1;
    step();
    check("bp_release_rob", 64'(iss_rob), 64'd8);
    step();

    // 5: flush with a same-cycle dispatch
    iss_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_disp(4'(i + 2), 1'b1, 32'(i), 4'd0, 1'b1, 32'(i), 4'd0);
      step();
    end
    check("preflush_count", 64'(count), 64'd5);
    flush_in = 1'b1;
    set_disp(4'd12, 1'b1, 32'd5, 4'd0, 1'b1, 32'd5, 4'd0);
    step();
    idle();
    step();
    check("postflush_count", 64'(count), 64'd0);
    check("postflush_valid", 64'(iss_valid), 64'd0);

    // 6: age ordering
    set_disp(4'd4, 1'b1, 32'd4, 4'd0, 1'b1, 32'd4, 4'd0);
    step();
    set_disp(4'd9, 1'b0, 32'd0, 4'd6, 1'b1, 32'h99, 4'd0);
    step();
    set_disp(4'd2, 1'b0, 32'd0, 4'd6, 1'b1, 32'h22, 4'd0);
    step();
    idle();
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd6}; cdb_val = {32'h0, 32'h66};
    step();
    idle();
    step();
`ifdef RS_AGE_EN
    first_rob = 4'd9;
`else
    first_rob = 4'd2;
`endif
    check("age_first_rob", 64'(iss_rob), 64'(first_rob));
    step(); step();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      rdy_in      = ($urandom_range(0, 9) != 0);
      flush_in    = ($urandom_range(0, 39) == 0);
      iss_ready   = ($urandom_range(0, 3) != 0);
      disp_valid  = ($urandom_range(0, 2) != 0);
      disp_rob    = TAG_W'($urandom_range(0, 15));
      disp_op     = OP_W'($urandom_range(0, 63));
      disp_imm    = $urandom;
      disp_pc     = $urandom;
      disp_q1_rdy = ($urandom_range(0, 1) != 0);
      disp_q2_rdy = ($urandom_range(0, 1) != 0);
      disp_v1     = $urandom;
      disp_v2     = $urandom;
      disp_q1     = TAG_W'($urandom_range(0, 7));
      disp_q2     = TAG_W'($urandom_range(0, 7));
      cdb_valid   = N_CDB'($urandom_range(0, 3));
      cdb_tag     = {TAG_W'($urandom_range(0, 7)), TAG_W'($urandom_range(0, 7))};
      cdb_val     = {$urandom, $urandom};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
